// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Define MD_MADD_EN to build madd/maddu (ops 4/5); otherwise they are reserved.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t state, state_n;

    logic [CW-1:0] cnt;
    logic [31:0]   temp_hi, temp_lo;
    logic          is_mul, is_div, accept, done, sgn;
    logic [63:0]   opa, opb, prod, mres;
    logic [31:0]   ua, ub, uq, ur;
    logic [31:0]   dhi, dlo;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        unique case (md_op)
            3'd0, 3'd1: is_mul = 1'b1;
            3'd2, 3'd3: is_div = 1'b1;
`ifdef MD_MADD_EN
            3'd4, 3'd5: is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    assign busy   = (state != IDLE);
    assign accept = start && !busy && (is_mul || is_div);

    // Even ops (mult/div/madd) are signed, odd ones unsigned.
    assign sgn = ~md_op[0];

    // One 64-bit multiplier serves both signednesses via extension.
    assign opa  = sgn ? {{32{rs[31]}}, rs} : {32'b0, rs};
    assign opb  = sgn ? {{32{rt[31]}}, rt} : {32'b0, rt};
    assign prod = opa * opb;

`ifdef MD_MADD_EN
    assign mres = md_op[2] ? ({hi, lo} + prod) : prod;
`else
    assign mres = prod;
`endif

    // Signed divide on magnitudes; 0x80000000 / -1 falls out naturally.
    assign ua = (sgn && rs[31]) ? -rs : rs;
    assign ub = (sgn && rt[31]) ? -rt : rt;
    assign uq = (ub == 32'd0) ? 32'd0 : ua / ub;
    assign ur = (ub == 32'd0) ? 32'd0 : ua % ub;

    always_comb begin
        dlo = uq;
        dhi = ur;
        if (rt == 32'd0) begin
            dlo = 32'hFFFF_FFFF;
            dhi = rs;
        end else if (sgn) begin
            if (rs[31] ^ rt[31])
                dlo = -uq;
            if (rs[31])
                dhi = -ur;
        end
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_n = is_div ? DIV : MUL;
            end
            MUL, DIV: begin
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            temp_hi <= '0;
            temp_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (accept) begin
            cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            {temp_hi, temp_lo} <= is_div ? {dhi, dlo} : mres;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (done) begin
                hi <= temp_hi;
                lo <= temp_lo;
            end
        end else begin
            if (hi_we)
                hi <= wdata;
            if (lo_we)
                lo <= wdata;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Expectations for ops 4/5 follow MD_MADD_EN.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    int cyc;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .rs    (rs),
        .rt    (rt),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then count busy cycles (bounded).
    // At busy cycle 'poke' a mult start is driven and must be ignored.
    task automatic run_op(input logic [2:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int poke,
                          output int n);
        start = 1'b1;
        md_op = op;
        rs    = a;
        rt    = b;
        step();
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == poke) begin
                start = 1'b1;
                md_op = 3'd0;
                rs    = 32'd3;
                rt    = 32'd3;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        rs    = '0;
        rt    = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        step();
        step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b1;
        step();

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0, cyc);
        check("mult_cyc", 32'(cyc), 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        run_op(3'd3, 32'd100, 32'd7, 4, cyc);
        check("divu_cyc", 32'(cyc), 32'd10);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        step();
        check("noqueue_busy", {31'b0, busy}, 32'd0);
        check("noqueue_lo", lo, 32'd14);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, cyc);
        check("div_cyc", 32'(cyc), 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(3'd2, 32'd5, 32'd0, 0, cyc);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'd5);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        run_op(3'd6, 32'd9, 32'd9, 0, cyc);
        check("rsv_cyc", 32'(cyc), 32'd0);
        check("rsv_busy", {31'b0, busy}, 32'd0);
        check("rsv_lo", lo, 32'h8000_0000);

        hi_we = 1'b1;
        wdata = 32'h1234;
        step();
        hi_we = 1'b0;
        check("mthi", hi, 32'h1234);
        lo_we = 1'b1;
        wdata = 32'h55;
        step();
        lo_we = 1'b0;
        check("mtlo", lo, 32'h55);
        check("mtlo_hi", hi, 32'h1234);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h77;
        step();
        lo_we = 1'b0;
        check("both_hi", hi, 32'h77);
        check("both_lo", lo, 32'h77);

        // hi_we stays high across accept and the whole busy window
        wdata = 32'h1234;
        run_op(3'd1, 32'd2, 32'd2, 0, cyc);
        hi_we = 1'b0;
        check("we_cyc", 32'(cyc), 32'd5);
        check("we_hi", hi, 32'd0);
        check("we_lo", lo, 32'd4);
        step();
        check("we_hi2", hi, 32'd0);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        start = 1'b1;
        md_op = 3'd1;
        rs    = 32'hFFFF_FFFF;
        rt    = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        step();
        check("abort_pre", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        for (int i = 0; i < 10; i++)
            step();
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);
        check("abort_late_busy", {31'b0, busy}, 32'd0);

        hi_we = 1'b1;
        wdata = 32'd0;
        step();
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'hFFFF_FFFF;
        step();
        lo_we = 1'b0;
        run_op(3'd5, 32'd1, 32'd1, 0, cyc);
`ifdef MD_MADD_EN
        check("maddu_cyc", 32'(cyc), 32'd5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
        run_op(3'd4, 32'hFFFF_FFFF, 32'd1, 0, cyc);
        check("madd_cyc", 32'(cyc), 32'd5);
        check("madd_hi", hi, 32'd0);
        check("madd_lo", lo, 32'hFFFF_FFFF);
`else
        check("maddu_cyc", 32'(cyc), 32'd0);
        check("maddu_hi", hi, 32'd0);
        check("maddu_lo", lo, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFFF, 32'd1, 0, cyc);
        check("madd_cyc", 32'(cyc), 32'd0);
        check("madd_hi", hi, 32'd0);
        check("madd_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
